cic_sample_buffer: RTL and testbench
====================================

CIC_SAMPLE_BUFFER -- requirements
Module: cic_sample_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 10, is the CIC output sample width and matches the CIC register_width.
REQ-002 Parameter FIFO_DEPTH, default 8, is the number of buffered samples; it SHALL be a power of two and at least 2.
REQ-003 clk_i  input  1  single clock, same clock that drives the CIC stage.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 cic_i  input  DATA_WIDTH  decimated CIC sample, stable around the rising edge of cic_clk_i.
REQ-006 cic_clk_i  input  1  CIC decimation strobe, high for half the decimation period, synchronous to clk_i.
REQ-007 ready_i  input  1  downstream consumer accepts sample_o this cycle.
REQ-008 clear_ovf_i  input  1  clears the sticky overflow flag.
REQ-009 sample_o  output  DATA_WIDTH  oldest buffered sample (FIFO head).
REQ-010 valid_o  output  1  sample_o holds a valid sample.
REQ-011 count_o  output  $clog2(FIFO_DEPTH)+1  number of samples currently buffered.
REQ-012 overflow_o  output  1  sticky flag: at least one sample was dropped.

Function
REQ-013 The block SHALL register cic_clk_i once into cic_clk_q; a capture event is cic_clk_i==1 and cic_clk_q==0 in the same cycle.
REQ-014 On a capture event, cic_i SHALL be written into the FIFO at that clock edge, and valid_o SHALL be high in the next cycle if the FIFO was empty (1-cycle latency).
REQ-015 A cic_clk_i that stays high SHALL produce exactly one capture event; a cic_clk_i high at reset release SHALL NOT produce one, because cic_clk_q resets to 1.
REQ-016 The FIFO is first-word-fall-through: sample_o equals the head entry whenever valid_o is 1, and sample_o is 0 when the FIFO is empty.
REQ-017 valid_o SHALL equal (count_o != 0).
REQ-018 A pop SHALL occur when valid_o and ready_i are both 1; the head then advances at that edge.
REQ-019 ready_i while valid_o is 0 SHALL have no effect.
REQ-020 A capture and a pop in the same cycle SHALL both take effect, leaving count_o unchanged, including when the FIFO is full.
REQ-021 A capture while full without a pop SHALL drop the new sample, leave the FIFO contents unchanged and set overflow_o at that edge.
REQ-022 overflow_o SHALL stay set until clear_ovf_i is 1; if clear and a new drop coincide, set wins and overflow_o stays 1.
REQ-023 A capture while empty together with ready_i SHALL NOT bypass: the sample appears on the next cycle.
REQ-024 Read and write pointers SHALL be $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; count_o tracks full (FIFO_DEPTH) and empty (0) unambiguously.
REQ-025 Samples SHALL be treated as unsigned and passed through unmodified; there is no arithmetic on the data path.

Reset
REQ-026 On rst_i high at a clock edge, the block SHALL set count_o=0, valid_o=0, sample_o=0, overflow_o=0, pointers=0 and cic_clk_q=1.
REQ-027 Reset asserted mid-operation SHALL discard all buffered samples within that cycle; storage contents need not be cleared.
REQ-028 A capture event coinciding with rst_i SHALL be ignored.

Structure
REQ-029 Package cic_pkg SHALL hold the default DATA_WIDTH (10) and FIFO_DEPTH (8) constants shared with the CIC stage.
REQ-030 The storage SHALL be one sub-module, cic_fifo: a synchronous FWFT FIFO with push, pop, full, empty and count.
REQ-031 Edge detection and overflow logic SHALL live in cic_sample_buffer.

Verification
REQ-032 Reset: with cic_clk_i=1 held through reset release, there SHALL be no capture, valid_o=0 and count_o=0.
REQ-033 Single sample: cic_clk_i rises with cic_i=10'h155 and ready_i=0 -> valid_o=1 and sample_o=10'h155 one cycle later, and count_o=1.
REQ-034 Order and throughput: capture 5 samples 1..5 with ready_i=1 -> each sample is output exactly once, in order, and count_o returns to 0.
REQ-035 Overflow: hold ready_i=0 and capture 9 samples with FIFO_DEPTH=8 -> count_o=8, overflow_o=1 and the head is sample 1; then pulse clear_ovf_i -> overflow_o=0.
REQ-036 Full with simultaneous push and pop: when full and ready_i=1 at a capture -> count_o stays 8, overflow_o stays 0 and the new sample is stored at the tail.
REQ-037 Mid-operation reset: assert rst_i with count_o=3 -> next cycle count_o=0, valid_o=0 and sample_o=0.

Source files
------------

// File: rtl/cic_pkg.sv
// Constants shared between the CIC decimator and its output sample buffer.
// Defaults here must match the CIC register width and the buffer depth it was sized for.
package cic_pkg;

    localparam int CIC_DATA_WIDTH = 10;
    localparam int CIC_FIFO_DEPTH = 8;

endpackage : cic_pkg

// File: rtl/cic_fifo.sv
// Synchronous first-word-fall-through FIFO; a write is visible at the head one cycle later.
// A full FIFO accepts a push only together with a pop; an empty FIFO ignores pop (no bypass).
module cic_fifo
    import cic_pkg::*;
#(
    parameter int WIDTH = CIC_DATA_WIDTH,
    parameter int DEPTH = CIC_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // When full, the slot freed by a same-cycle pop is the one the push lands in.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = empty ? '0 : mem[rd_ptr];
    assign count = count_q;

    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count_q <= (AW+1)'(DEPTH));

    a_ptr_gap : assert property (@(posedge clk) disable iff (rst)
        (wr_ptr - rd_ptr) == count_q[AW-1:0]);

endmodule : cic_fifo

// File: rtl/cic_sample_buffer.sv
// Captures one CIC sample per decimation strobe rising edge into a FWFT FIFO; 1-cycle capture-to-valid latency.
// Downstream pops on valid_o && ready_i; a capture into a full FIFO without a pop is dropped and flagged sticky.
module cic_sample_buffer
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH = CIC_DATA_WIDTH,
    parameter int FIFO_DEPTH = CIC_FIFO_DEPTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [DATA_WIDTH-1:0]       cic_i,
    input  logic                        cic_clk_i,
    input  logic                        ready_i,
    input  logic                        clear_ovf_i,
    output logic [DATA_WIDTH-1:0]       sample_o,
    output logic                        valid_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        overflow_o
);

    logic                  cic_clk_q;
    logic                  capture;
    logic                  pop;
    logic                  drop;
    logic                  full;
    logic                  empty;
    logic                  overflow_q;
    logic [DATA_WIDTH-1:0] head;

    // Resetting the delayed strobe high suppresses a capture for a strobe already high at release.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cic_clk_q <= 1'b1;
        end else begin
            cic_clk_q <= cic_clk_i;
        end
    end

    assign capture = cic_clk_i && !cic_clk_q && !rst_i;
    assign pop     = !empty && ready_i;
    assign drop    = capture && full && !pop;

    cic_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (capture),
        .push_data (cic_i),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count_o)
    );

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clear_ovf_i) begin
            overflow_q <= 1'b0;
        end
    end

    assign sample_o   = head;
    assign valid_o    = !empty;
    assign overflow_o = overflow_q;

    a_drop_flags : assert property (@(posedge clk_i) disable iff (rst_i)
        drop |=> overflow_o);

    a_valid_count : assert property (@(posedge clk_i)
        valid_o == (count_o != '0));

endmodule : cic_sample_buffer

// File: tb/tb_cic_sample_buffer.sv
// Directed scenarios plus randomized traffic for cic_sample_buffer, checked against a queue-based model.
module tb_cic_sample_buffer;

    localparam int DW    = 10;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] cic_data = '0;
    logic          cic_clk = 1'b1;
    logic          ready = 1'b0;
    logic          clear_ovf = 1'b0;
    logic [DW-1:0] sample;
    logic          valid;
    logic [3:0]    count;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] popped[$];
    bit            m_ovf  = 1'b0;
    bit            m_prev = 1'b1;

    cic_sample_buffer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cic_i       (cic_data),
        .cic_clk_i   (cic_clk),
        .ready_i     (ready),
        .clear_ovf_i (clear_ovf),
        .sample_o    (sample),
        .valid_o     (valid),
        .count_o     (count),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    // One clock: record DUT pops, advance the model by the buffer's rules, settle 1 time unit past the edge.
    task automatic tick();
        bit cap;
        bit mpop;
        bit drop;
        cap  = cic_clk && !m_prev && !rst;
        mpop = (mq.size() != 0) && ready && !rst;
        if (valid && ready && !rst) popped.push_back(sample);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_prev = 1'b1;
        end else begin
            drop = cap && (mq.size() == DEPTH) && !mpop;
            if (mpop) void'(mq.pop_front());
            if (cap && !drop) mq.push_back(cic_data);
            if (drop) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
            m_prev = cic_clk;
        end
        #1;
    endtask

    task automatic capture(input logic [DW-1:0] d);
        cic_data = d;
        cic_clk  = 1'b1;
        tick();
        cic_clk  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; cic_clk = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", valid); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (sample !== 10'h000) begin n_fail++; $display("FAIL reset_sample: got %0h expected 0", sample); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    endtask

    task automatic test_single();
        cic_clk = 1'b0; ready = 1'b1;
        tick();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL ready_when_empty: got count %0d expected 0", count); end
        ready = 1'b0; cic_data = 10'h155; cic_clk = 1'b1;
        tick();
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", valid); end
        n_checks++; if (sample !== 10'h155) begin n_fail++; $display("FAIL single_sample: got %0h expected 155", sample); end
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
        tick();
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL held_strobe_count: got %0d expected 1", count); end
        cic_clk = 1'b0; ready = 1'b1;
        tick();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL single_pop: got count %0d expected 0", count); end
        cic_data = 10'h2C3; cic_clk = 1'b1;
        tick();
        n_checks++; if (count !== 4'd1 || sample !== 10'h2C3) begin
            n_fail++; $display("FAIL no_bypass: got count %0d sample %0h expected 1 2c3", count, sample);
        end
        cic_clk = 1'b0;
        tick();
        ready = 1'b0;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL no_bypass_drain: got %0d expected 0", count); end
    endtask

    task automatic test_order();
        popped.delete();
        ready = 1'b1;
        for (int i = 1; i <= 5; i++) capture(10'(i));
        tick(); tick();
        ready = 1'b0;
        n_checks++; if (popped.size() !== 5) begin n_fail++; $display("FAIL order_npop: got %0d expected 5", popped.size()); end
        for (int i = 0; i < 5 && i < popped.size(); i++) begin
            n_checks++;
            if (popped[i] !== 10'(i + 1)) begin n_fail++; $display("FAIL order_item%0d: got %0h expected %0h", i, popped[i], i + 1); end
        end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL order_count: got %0d expected 0", count); end
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        for (int i = 1; i <= 9; i++) capture(10'(i));
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d expected 8", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        n_checks++; if (sample !== 10'd1) begin n_fail++; $display("FAIL ovf_head: got %0h expected 1", sample); end
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
        cic_data = 10'd10; cic_clk = 1'b1; clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0; cic_clk = 1'b0;
        tick();
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %0b expected 1", overflow); end
        n_checks++; if (count !== 4'd8 || sample !== 10'd1) begin
            n_fail++; $display("FAIL ovf_unchanged: got count %0d head %0h expected 8 1", count, sample);
        end
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp_tail[8];
        exp_tail = '{10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'h2AA};
        cic_data = 10'h2AA; cic_clk = 1'b1; ready = 1'b1;
        tick();
        ready = 1'b0; cic_clk = 1'b0;
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fullpp_count: got %0d expected 8", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp_ovf: got %0b expected 0", overflow); end
        n_checks++; if (sample !== 10'd2) begin n_fail++; $display("FAIL fullpp_head: got %0h expected 2", sample); end
        tick();
        popped.delete();
        ready = 1'b1;
        repeat (10) tick();
        ready = 1'b0;
        n_checks++; if (popped.size() !== 8) begin n_fail++; $display("FAIL fullpp_npop: got %0d expected 8", popped.size()); end
        for (int i = 0; i < 8 && i < popped.size(); i++) begin
            n_checks++;
            if (popped[i] !== exp_tail[i]) begin n_fail++; $display("FAIL fullpp_item%0d: got %0h expected %0h", i, popped[i], exp_tail[i]); end
        end
    endtask

    task automatic test_mid_reset();
        ready = 1'b0;
        capture(10'h3FF); capture(10'h000); capture(10'h123);
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL midrst_pre: got %0d expected 3", count); end
        rst = 1'b1; cic_clk = 1'b1; cic_data = 10'h0AB;
        tick();
        rst = 1'b0;
        n_checks++; if (count !== 4'd0 || valid !== 1'b0 || sample !== 10'h000) begin
            n_fail++; $display("FAIL midrst_clear: got count %0d valid %0b sample %0h expected 0 0 0", count, valid, sample);
        end
        tick();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL midrst_no_capture: got %0d expected 0", count); end
        cic_clk = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int pct;
        logic [DW-1:0] exp_s;
        for (int c = 0; c < 4000; c++) begin
            case ((c / 500) % 4)
                0: pct = 10;
                1: pct = 50;
                2: pct = 90;
                default: pct = 30;
            endcase
            if ($urandom_range(0, 1) == 1) cic_clk = ~cic_clk;
            cic_data  = DW'($urandom);
            ready     = ($urandom_range(0, 99) < pct);
            clear_ovf = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            tick();
            exp_s = (mq.size() != 0) ? mq[0] : '0;
            n_checks++; if (count !== 4'(mq.size())) begin n_fail++; $display("FAIL rand_count c=%0d: got %0d expected %0d", c, count, mq.size()); end
            n_checks++; if (valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_valid c=%0d: got %0b", c, valid); end
            n_checks++; if (sample !== exp_s) begin n_fail++; $display("FAIL rand_sample c=%0d: got %0h expected %0h", c, sample, exp_s); end
            n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf c=%0d: got %0b expected %0b", c, overflow, m_ovf); end
        end
        rst = 1'b0; clear_ovf = 1'b0; ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cic_sample_buffer
